player_motion: RTL and testbench

- Downstream consumer of the wall placement block's X1..X4/Y1..Y4 outputs.
- Once per video frame, moves the player sprite one step according to the keyboard keycode.
- Rejects any move whose player box would overlap a wall box or leave the screen.
- Feeds PlayerX/PlayerY to the sprite/colour mapper and exposes per-wall hit flags for game logic.

---
 rtl/player_motion_if.sv | 24 ++
 rtl/player_motion.sv | 161 ++++++++++++++++
 tb/tb_player_motion.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// rtl/player_motion_if.sv - frame trigger, keycode, wall coordinates and player status bundle
interface player_motion_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] X1, X2, X3, X4;
  logic [9:0] Y1, Y2, Y3, Y4;
  logic [9:0] PlayerX, PlayerY;
  logic [3:0] hit_wall;
  logic       blocked;
  logic       done;
  logic       busy;

  // Stimulus / game side: drives frame trigger, keycode and walls, observes the player.
  modport master (
    output frame_clk, keycode, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
    input  PlayerX, PlayerY, hit_wall, blocked, done, busy
  );

  // Motion block side.
  modport slave (
    input  frame_clk, keycode, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
    output PlayerX, PlayerY, hit_wall, blocked, done, busy
  );
endinterface

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-frame player step with screen-edge clamp and four-wall collision test
module player_motion #(
  parameter logic [9:0] PLAYER_SIZE = 10'd16,
  parameter logic [9:0] STEP        = 10'd2,
  parameter logic [9:0] X_START     = 10'd320,
  parameter logic [9:0] Y_START     = 10'd240,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479,
  parameter logic [9:0] HOR_W       = 10'd64,
  parameter logic [9:0] HOR_H       = 10'd32,
  parameter logic [9:0] VERT_W      = 10'd32,
  parameter logic [9:0] VERT_H      = 10'd64
) (
  input  logic           Clk,
  input  logic           Reset,
  player_motion_if.slave pm
);
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {IDLE, CALC, CHECK, UPDATE} state_t;

  state_t          state;
  state_t          state_next;
  logic            frame_prev;
  logic            frame_rise;
  logic [3:0][9:0] snap_x;
  logic [3:0][9:0] snap_y;
  logic [7:0]      snap_key;
  logic [9:0]      cx;
  logic [9:0]      cy;
  logic [9:0]      cx_next;
  logic [9:0]      cy_next;
  logic [1:0]      idx;
  logic [3:0]      hit;
  logic [9:0]      player_x;
  logic [9:0]      player_y;
  logic [3:0]      hit_wall_q;
  logic            blocked_q;
  logic [10:0]     x_right;
  logic [10:0]     y_down;
  logic [10:0]     wall_x;
  logic [10:0]     wall_y;
  logic [10:0]     wall_w;
  logic [10:0]     wall_h;
  logic [10:0]     cand_x;
  logic [10:0]     cand_y;
  logic            overlap;

  // Only a low-to-high transition of the vsync pulse starts an update.
  assign frame_rise = pm.frame_clk & ~frame_prev;

  // Forward-step positions are 11 bits wide so the right/bottom edge test cannot wrap.
  assign x_right = {1'b0, player_x} + {1'b0, STEP};
  assign y_down  = {1'b0, player_y} + {1'b0, STEP};

  // Candidate position: one step along the keyed axis, held on that axis if it would leave the screen.
  always_comb begin
    cx_next = player_x;
    cy_next = player_y;
    case (snap_key)
      KEY_W: if (player_y >= STEP) cy_next = player_y - STEP;
      KEY_S: if (y_down + {1'b0, PLAYER_SIZE} - 11'd1 <= {1'b0, Y_MAX}) cy_next = y_down[9:0];
      KEY_A: if (player_x >= STEP) cx_next = player_x - STEP;
      KEY_D: if (x_right + {1'b0, PLAYER_SIZE} - 11'd1 <= {1'b0, X_MAX}) cx_next = x_right[9:0];
      default: ;
    endcase
  end

  // Inclusive box overlap between the candidate and the wall selected by idx; odd idx are the vertical walls.
  always_comb begin
    wall_x  = {1'b0, snap_x[idx]};
    wall_y  = {1'b0, snap_y[idx]};
    wall_w  = idx[0] ? {1'b0, VERT_W} : {1'b0, HOR_W};
    wall_h  = idx[0] ? {1'b0, VERT_H} : {1'b0, HOR_H};
    cand_x  = {1'b0, cx};
    cand_y  = {1'b0, cy};
    overlap = (cand_x <= wall_x + wall_w) &&
              (cand_x + {1'b0, PLAYER_SIZE} - 11'd1 >= wall_x) &&
              (cand_y <= wall_y + wall_h) &&
              (cand_y + {1'b0, PLAYER_SIZE} - 11'd1 >= wall_y);
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: CHECK walks idx 0..3, so it lasts exactly four cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_rise) state_next = CALC;
      CALC:    state_next = CHECK;
      CHECK:   if (idx == 2'd3) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: snapshot, candidate, per-wall hit collection and commit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_prev <= 1'b0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_key   <= 8'h00;
      cx         <= 10'd0;
      cy         <= 10'd0;
      idx        <= 2'd0;
      hit        <= 4'd0;
      player_x   <= X_START;
      player_y   <= Y_START;
      hit_wall_q <= 4'd0;
      blocked_q  <= 1'b0;
    end else begin
      frame_prev <= pm.frame_clk;
      case (state)
        IDLE: begin
          if (frame_rise) begin
            snap_x   <= {pm.X4, pm.X3, pm.X2, pm.X1};
            snap_y   <= {pm.Y4, pm.Y3, pm.Y2, pm.Y1};
            snap_key <= pm.keycode;
          end
        end
        CALC: begin
          cx  <= cx_next;
          cy  <= cy_next;
          idx <= 2'd0;
          hit <= 4'd0;
        end
        CHECK: begin
          hit[idx] <= overlap;
          idx      <= idx + 2'd1;
        end
        UPDATE: begin
          hit_wall_q <= hit;
          blocked_q  <= |hit;
          if (~|hit) begin
            player_x <= cx;
            player_y <= cy;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: done marks the commit cycle, busy covers every non-idle state.
  always_comb begin
    pm.done     = (state == UPDATE);
    pm.busy     = (state != IDLE);
    pm.PlayerX  = player_x;
    pm.PlayerY  = player_y;
    pm.hit_wall = hit_wall_q;
    pm.blocked  = blocked_q;
  end
endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - scoreboard bench for player_motion against a box-geometry reference model
module tb_player_motion;
  logic Clk = 1'b0;
  logic Reset;
  player_motion_if pm();

  player_motion dut (
    .Clk   (Clk),
    .Reset (Reset),
    .pm    (pm)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int         x;
    int         y;
    logic [3:0] hit;
    logic       blk;
    int         done_cycle;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   mx       = 320;
  int   my       = 240;
  int   wx[4];
  int   wy[4];

  always @(posedge Clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_walls();
    pm.X1 = 10'(wx[0]); pm.X2 = 10'(wx[1]); pm.X3 = 10'(wx[2]); pm.X4 = 10'(wx[3]);
    pm.Y1 = 10'(wy[0]); pm.Y2 = 10'(wy[1]); pm.Y3 = 10'(wy[2]); pm.Y4 = 10'(wy[3]);
  endtask

  task automatic park();
    for (int i = 0; i < 4; i++) begin
      wx[i] = 1000;
      wy[i] = 1000;
    end
    set_walls();
  endtask

  // Reference: player occupies [x, x+15]^2; a wall occupies [wx, wx+w] x [wy, wy+h].
  function automatic exp_t model(input logic [7:0] key);
    exp_t e;
    int nx = mx;
    int ny = my;
    int w, h;
    case (key)
      8'h1A: if (my - 2 >= 0) ny = my - 2;
      8'h16: if (my + 2 + 15 <= 479) ny = my + 2;
      8'h04: if (mx - 2 >= 0) nx = mx - 2;
      8'h07: if (mx + 2 + 15 <= 639) nx = mx + 2;
      default: ;
    endcase
    e.hit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? 64 : 32;
      h = (i % 2 == 0) ? 32 : 64;
      if (nx <= wx[i] + w && wx[i] <= nx + 15 && ny <= wy[i] + h && wy[i] <= ny + 15)
        e.hit[i] = 1'b1;
    end
    e.blk = |e.hit;
    e.x = e.blk ? mx : nx;
    e.y = e.blk ? my : ny;
    e.done_cycle = 0;
    return e;
  endfunction

  // Issue one update; 'mode' 0 = plain, 1 = second edge while busy, 2 = wall 1 moved during CHECK.
  task automatic frame(input logic [7:0] key, input int hold, input int mode);
    exp_t e;
    @(posedge Clk); #1;
    pm.keycode = key;
    e = model(key);
    e.done_cycle = cycle + 6;
    sb.push_back(e);
    mx = e.x;
    my = e.y;
    pm.frame_clk = 1'b1;
    repeat (hold) @(posedge Clk);
    #1 pm.frame_clk = 1'b0;
    if (mode == 1) begin
      @(posedge Clk); #1 pm.frame_clk = 1'b1;
      @(posedge Clk); #1 pm.frame_clk = 1'b0;
    end else if (mode == 2) begin
      @(posedge Clk); #1;
      wx[0] = 1000;
      set_walls();
    end
    repeat (8) @(posedge Clk);
    #1;
  endtask

  task automatic move_to(input int tx, input int ty);
    park();
    for (int n = 0; n < 400 && mx > tx; n++) frame(8'h04, 1, 0);
    for (int n = 0; n < 400 && mx < tx; n++) frame(8'h07, 1, 0);
    for (int n = 0; n < 400 && my > ty; n++) frame(8'h1A, 1, 0);
    for (int n = 0; n < 400 && my < ty; n++) frame(8'h16, 1, 0);
  endtask

  // Monitor: every done pulse must match the oldest expectation, in timing and in committed outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (pm.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cycle, e.done_cycle);
          @(posedge Clk); #1;
          check("PlayerX", int'(pm.PlayerX), e.x);
          check("PlayerY", int'(pm.PlayerY), e.y);
          check("hit_wall", int'(pm.hit_wall), int'(e.hit));
          check("blocked", int'(pm.blocked), int'(e.blk));
          check("done_one_cycle", int'(pm.done), 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [7:0] keys[6];
    int         v;
    Reset = 1'b1;
    pm.frame_clk = 1'b0;
    pm.keycode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      wx[i] = 600;
      wy[i] = 600;
    end
    set_walls();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    check("rst_PlayerX", int'(pm.PlayerX), 320);
    check("rst_PlayerY", int'(pm.PlayerY), 240);
    check("rst_hit_wall", int'(pm.hit_wall), 0);
    check("rst_blocked", int'(pm.blocked), 0);
    check("rst_done", int'(pm.done), 0);
    check("rst_busy", int'(pm.busy), 0);

    // Free move with distant walls.
    frame(8'h07, 1, 0);
    check("free_PlayerX", int'(pm.PlayerX), 322);

    // Horizontal wall 1 at (100,100).
    move_to(84, 110);
    wx[0] = 100; wy[0] = 100; set_walls();
    frame(8'h07, 1, 0);
    check("w1_block_PlayerX", int'(pm.PlayerX), 84);
    check("w1_block_hit", int'(pm.hit_wall), 1);
    check("w1_block_blocked", int'(pm.blocked), 1);
    move_to(82, 110);
    wx[0] = 100; wy[0] = 100; set_walls();
    frame(8'h07, 1, 0);
    check("w1_clear_PlayerX", int'(pm.PlayerX), 84);
    check("w1_clear_blocked", int'(pm.blocked), 0);

    // Vertical wall 2 at (200,50), inclusive bottom edge at 114.
    move_to(210, 116);
    wx[1] = 200; wy[1] = 50; set_walls();
    frame(8'h1A, 1, 0);
    check("w2_block_PlayerY", int'(pm.PlayerY), 116);
    check("w2_block_hit", int'(pm.hit_wall), 2);
    move_to(210, 118);
    wx[1] = 200; wy[1] = 50; set_walls();
    frame(8'h1A, 1, 0);
    check("w2_clear_PlayerY", int'(pm.PlayerY), 116);
    check("w2_clear_blocked", int'(pm.blocked), 0);

    // Screen edges.
    move_to(0, 0);
    frame(8'h04, 1, 0);
    check("edge_left_PlayerX", int'(pm.PlayerX), 0);
    check("edge_left_blocked", int'(pm.blocked), 0);
    move_to(624, 0);
    frame(8'h07, 1, 0);
    check("edge_right_PlayerX", int'(pm.PlayerX), 624);

    // Wall 1 moved away during CHECK: the snapshot still blocks.
    wx[0] = 560; wy[0] = 0; set_walls();
    frame(8'h04, 1, 2);
    check("snap_PlayerX", int'(pm.PlayerX), 624);
    check("snap_blocked", int'(pm.blocked), 1);

    // Second edge while busy is dropped; a long-held level does not retrigger.
    park();
    frame(8'h04, 1, 1);
    check("overrun_PlayerX", int'(pm.PlayerX), 622);
    frame(8'h04, 12, 0);
    check("hold_PlayerX", int'(pm.PlayerX), 620);

    // Randomized keys and walls, often clustered around the player.
    keys[0] = 8'h1A; keys[1] = 8'h04; keys[2] = 8'h16; keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;
    move_to(300, 240);
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          v = mx + int'($urandom_range(0, 120)) - 80;
          wx[i] = (v < 0) ? 0 : v;
          v = my + int'($urandom_range(0, 120)) - 80;
          wy[i] = (v < 0) ? 0 : v;
        end else begin
          wx[i] = int'($urandom_range(0, 1023));
          wy[i] = int'($urandom_range(0, 1023));
        end
      end
      set_walls();
      frame(keys[$urandom_range(0, 5)], int'($urandom_range(1, 3)), 0);
    end

    // Reset in the middle of CHECK.
    move_to(100, 100);
    @(posedge Clk); #1;
    pm.keycode = 8'h07;
    pm.frame_clk = 1'b1;
    @(posedge Clk); #1 pm.frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_PlayerX", int'(pm.PlayerX), 320);
    check("midrst_PlayerY", int'(pm.PlayerY), 240);
    check("midrst_busy", int'(pm.busy), 0);
    check("midrst_done", int'(pm.done), 0);
    mx = 320;
    my = 240;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    check("post_rst_PlayerX", int'(pm.PlayerX), 320);
    check("pending_expectations", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
